fb_write_scheduler: RTL



---
 rtl/fb_write_scheduler.sv | 102 ++++++++++
 1 files changed

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: round-robin arbiter of two write requesters onto BRAM port A,
// with a full-buffer clear engine that takes priority while sweeping.
module fb_write_scheduler #(
  parameter int                    DATA_WIDTH = 1,
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DEPTH      = 1000000,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  input  logic                  clear_start_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic                  err_oob_o,
  output logic                  wea_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic [DATA_WIDTH-1:0] dina_o
);
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_e                state_q, state_d;
  logic                  rr_q, rr_d, wea_q, wea_d, done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addra_q, addra_d, sel_addr;
  logic [DATA_WIDTH-1:0] dina_q, dina_d, sel_data;
  logic                  g0, g1, oob;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // rr_q names the requester preferred when both are valid
  always_comb begin
    g0       = state_q == IDLE && !clear_start_i && req0_valid_i && (!req1_valid_i || !rr_q);
    g1       = state_q == IDLE && !clear_start_i && req1_valid_i && (!req0_valid_i || rr_q);
    sel_addr = g1 ? req1_addr_i : req0_addr_i;
    sel_data = g1 ? req1_data_i : req0_data_i;
    oob      = sel_addr > LAST;
    state_d  = state_q;
    rr_d     = g0 ? 1'b1 : g1 ? 1'b0 : rr_q;
    cnt_d    = cnt_q;
    wea_d    = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == CLEAR) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        wea_d   = 1'b1;
        addra_d = cnt_q + ADDR_WIDTH'(1);
        dina_d  = CLEAR_VAL;
      end
    end else if (clear_start_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
      wea_d   = 1'b1;
      addra_d = '0;
      dina_d  = CLEAR_VAL;
    end else if (g0 || g1) begin
      addra_d = sel_addr;
      dina_d  = sel_data;
      wea_d   = !oob;
      err_d   = oob;
    end
  end
  assign req0_ready_o = g0;
  assign req1_ready_o = g1;
  assign clear_busy_o = state_q == CLEAR;
  assign clear_done_o = done_q;
  assign err_oob_o    = err_q;
  assign wea_o        = wea_q;
  assign addra_o      = addra_q;
  assign dina_o       = dina_q;
endmodule
